// File: rtl/rom_fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its ROM, decoder and execute-stage data port.
// The master modport is the controller side; slave is the environment side.
interface rom_fetch_ctrl_if;
    logic [7:0] rom_addr;
    logic       rom_read;
    logic       rom_ena;
    logic [7:0] rom_data;
    logic       ins_valid;
    logic       ins_ready;
    logic [3:0] ins_opcode;
    logic [3:0] ins_reg;
    logic [7:0] ins_operand;
    logic       ins_two_byte;
    logic [7:0] ins_pc;
    logic       dreq_valid;
    logic [7:0] dreq_addr;
    logic       dreq_ready;
    logic       drsp_valid;
    logic [7:0] drsp_data;
    logic       jump_valid;
    logic [7:0] jump_addr;
    logic       halted;
    logic [1:0] dbg_state;

    modport master (
        output rom_addr, rom_read, rom_ena,
        input  rom_data,
        output ins_valid, ins_opcode, ins_reg, ins_operand, ins_two_byte, ins_pc,
        input  ins_ready,
        input  dreq_valid, dreq_addr,
        output dreq_ready, drsp_valid, drsp_data,
        input  jump_valid, jump_addr,
        output halted, dbg_state
    );

    modport slave (
        input  rom_addr, rom_read, rom_ena,
        output rom_data,
        input  ins_valid, ins_opcode, ins_reg, ins_operand, ins_two_byte, ins_pc,
        output ins_ready,
        output dreq_valid, dreq_addr,
        input  dreq_ready, drsp_valid, drsp_data,
        output jump_valid, jump_addr,
        input  halted, dbg_state
    );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Instruction fetch sequencer for the 8-bit RISC CPU, sharing one ROM port with execute-stage data reads.
// Handshakes: ins_valid/ins_ready transfer when both are high on a rising edge; a data read is taken when dreq_valid and dreq_ready are both high.
module rom_fetch_ctrl (
    input  logic              clk,
    input  logic              rst,
    rom_fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {
        S_FETCH_OP  = 2'd0,
        S_FETCH_ARG = 2'd1,
        S_HOLD      = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic       r_last_data;
    logic       r_ins_valid;
    logic [7:0] r_opcode;
    logic [7:0] r_operand;
    logic       r_two_byte;
    logic [7:0] r_ins_pc;
    logic       r_drsp_valid;
    logic [7:0] r_drsp_data;
    logic       r_halted;

    logic       w_fetch_req;
    logic       w_data_grant;
    logic       w_fetch_grant;
    logic       w_is_two;

    assign w_fetch_req   = (r_state == S_FETCH_OP) || (r_state == S_FETCH_ARG);
    // Data wins unless it won last cycle while a fetch was waiting.
    assign w_data_grant  = !rst && bus.dreq_valid && !(r_last_data && w_fetch_req);
    assign w_fetch_grant = !rst && w_fetch_req && !w_data_grant;
    assign w_is_two      = (bus.rom_data[7:4] == 4'h1) || (bus.rom_data[7:4] == 4'h2) ||
                           (bus.rom_data[7:4] == 4'h3);

    assign bus.rom_addr   = w_data_grant ? bus.dreq_addr : (w_fetch_grant ? r_pc : 8'h00);
    assign bus.rom_read   = w_data_grant || w_fetch_grant;
    assign bus.rom_ena    = w_data_grant || w_fetch_grant;
    assign bus.dreq_ready = w_data_grant;

    assign bus.ins_valid    = r_ins_valid;
    assign bus.ins_opcode   = r_opcode[7:4];
    assign bus.ins_reg      = r_opcode[3:0];
    assign bus.ins_operand  = r_operand;
    assign bus.ins_two_byte = r_two_byte;
    assign bus.ins_pc       = r_ins_pc;
    assign bus.drsp_valid   = r_drsp_valid;
    assign bus.drsp_data    = r_drsp_data;
    assign bus.halted       = r_halted;
    assign bus.dbg_state    = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH_OP;
            r_pc         <= 8'h00;
            r_last_data  <= 1'b0;
            r_ins_valid  <= 1'b0;
            r_opcode     <= 8'h00;
            r_operand    <= 8'h00;
            r_two_byte   <= 1'b0;
            r_ins_pc     <= 8'h00;
            r_drsp_valid <= 1'b0;
            r_drsp_data  <= 8'h00;
            r_halted     <= 1'b0;
        end else begin
            r_last_data  <= w_data_grant;
            r_drsp_valid <= w_data_grant;
            if (w_data_grant) begin
                r_drsp_data <= bus.rom_data;
            end
            // A jump overrides any fetch progress; a same-cycle handshake is simply absorbed.
            if (bus.jump_valid) begin
                r_pc        <= bus.jump_addr;
                r_state     <= S_FETCH_OP;
                r_halted    <= 1'b0;
                r_ins_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_FETCH_OP: begin
                        if (w_fetch_grant) begin
                            r_opcode   <= bus.rom_data;
                            r_ins_pc   <= r_pc;
                            r_two_byte <= w_is_two;
                            r_pc       <= r_pc + 8'd1;
                            if (w_is_two) begin
                                r_state <= S_FETCH_ARG;
                            end else begin
                                r_operand   <= 8'h00;
                                r_ins_valid <= 1'b1;
                                r_state     <= S_HOLD;
                            end
                        end
                    end
                    S_FETCH_ARG: begin
                        if (w_fetch_grant) begin
                            r_operand   <= bus.rom_data;
                            r_pc        <= r_pc + 8'd1;
                            r_ins_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (bus.ins_ready) begin
                            r_ins_valid <= 1'b0;
                            if (r_opcode[7:4] == 4'h7) begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end else begin
                                r_state <= S_FETCH_OP;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_HALT;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Randomized bench for rom_fetch_ctrl against an instruction-level reference model.
module tb_rom_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_fetch_ctrl_if bus ();
  rom_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: PC, bytes gathered for the pending instruction, presented instruction.
  logic [7:0]  m_pc;
  logic [7:0]  m_bytes[$];
  logic [7:0]  m_ipc;
  logic [7:0]  m_op;
  logic [7:0]  m_operand;
  logic        m_two;
  logic        m_present;
  logic        m_halted;
  logic        m_last_data;
  logic        m_drsp_valid;
  logic [7:0]  m_drsp_data;
  logic        m_after_rst;
  logic [24:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int bytes_needed(input logic [7:0] op_byte);
    return (op_byte[7:4] >= 4'h1 && op_byte[7:4] <= 4'h3) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_pc = 8'h00; m_bytes.delete(); m_ipc = 8'h00; m_op = 8'h00; m_operand = 8'h00;
    m_two = 1'b0; m_present = 1'b0; m_halted = 1'b0; m_last_data = 1'b0;
    m_drsp_valid = 1'b0; m_drsp_data = 8'h00; m_after_rst = 1'b1; exp_q.delete();
  endtask

  task automatic step(input int p_dreq, input int p_ready, input int p_jump, input int p_rst,
                      input bit jump_ff);
    logic fetch_w, data_g, fetch_g;
    logic [7:0] exp_addr, b;
    logic [24:0] e;
    @(posedge clk);
    #1;
    rst            = ($urandom_range(0, 999) < p_rst);
    bus.dreq_valid = ($urandom_range(0, 99) < p_dreq);
    bus.dreq_addr  = 8'($urandom);
    bus.ins_ready  = ($urandom_range(0, 99) < p_ready);
    bus.jump_valid = ($urandom_range(0, 99) < p_jump);
    bus.jump_addr  = jump_ff ? 8'hFF : (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    #2;
    fetch_w  = !m_halted && !m_present;
    data_g   = !rst && bus.dreq_valid && !(m_last_data && fetch_w);
    fetch_g  = !rst && fetch_w && !data_g;
    exp_addr = data_g ? bus.dreq_addr : (fetch_g ? m_pc : 8'h00);
    check_eq("rom_read", 32'(bus.rom_read), 32'(data_g || fetch_g));
    check_eq("rom_ena", 32'(bus.rom_ena), 32'(data_g || fetch_g));
    check_eq("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
    check_eq("dreq_ready", 32'(bus.dreq_ready), 32'(data_g));
    check_eq("ins_valid", 32'(bus.ins_valid), 32'(m_present));
    check_eq("halted", 32'(bus.halted), 32'(m_halted));
    check_eq("drsp_valid", 32'(bus.drsp_valid), 32'(m_drsp_valid));
    check_eq("drsp_data", 32'(bus.drsp_data), 32'(m_drsp_data));
    if (m_present) begin
      check_eq("ins_fields", {bus.ins_pc, bus.ins_opcode, bus.ins_reg, bus.ins_operand, bus.ins_two_byte},
               {m_ipc, m_op, m_operand, m_two});
    end
    if (m_after_rst) begin
      check_eq("ins_reset", {bus.ins_pc, bus.ins_opcode, bus.ins_reg, bus.ins_operand, bus.ins_two_byte}, 0);
    end
    if (m_present && bus.ins_ready && !rst) begin
      if (exp_q.size() == 0) check_eq("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("sb_ins", {bus.ins_pc, bus.ins_opcode, bus.ins_reg, bus.ins_operand, bus.ins_two_byte}, e);
      end
    end
    // Advance the model across the coming rising edge.
    if (rst) begin
      model_reset();
    end else begin
      m_after_rst  = 1'b0;
      m_last_data  = data_g;
      m_drsp_valid = data_g;
      if (data_g) m_drsp_data = rom[bus.dreq_addr];
      if (bus.jump_valid) begin
        if (m_present && !bus.ins_ready) exp_q.delete();
        m_pc = bus.jump_addr; m_bytes.delete(); m_present = 1'b0; m_halted = 1'b0;
      end else if (m_present) begin
        if (bus.ins_ready) begin
          m_present = 1'b0;
          if (m_op[7:4] == 4'h7) m_halted = 1'b1;
        end
      end else if (fetch_g) begin
        b = rom[m_pc];
        if (m_bytes.size() == 0) m_ipc = m_pc;
        m_bytes.push_back(b);
        m_pc = m_pc + 8'd1;
        if (m_bytes.size() == bytes_needed(m_bytes[0])) begin
          m_op      = m_bytes[0];
          m_two     = (m_bytes.size() == 2);
          m_operand = m_two ? m_bytes[1] : 8'h00;
          m_present = 1'b1;
          m_bytes.delete();
          exp_q.push_back({m_ipc, m_op, m_operand, m_two});
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h00; rom[1] = 8'h11; rom[2] = 8'h61; rom[8'h61] = 8'h15; rom[40] = 8'h70;
    rom[8'hFF] = 8'h45;
    rst = 1'b1;
    bus.dreq_valid = 1'b0; bus.dreq_addr = 8'h00; bus.ins_ready = 1'b0;
    bus.jump_valid = 1'b0; bus.jump_addr = 8'h00;
    repeat (3) @(posedge clk);
    model_reset();
    for (int i = 0; i < 40; i++)   step(0, 100, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++)   step(100, 100, 0, 0, 1'b0);
    for (int i = 0; i < 400; i++)  step(30, 70, 3, 5, 1'b0);
    for (int i = 0; i < 300; i++)  step(50, 20, 5, 3, 1'b1);
    for (int i = 0; i < 600; i++)  step(40, 60, 4, 4, 1'b0);
    for (int i = 0; i < 200; i++)  step(90, 90, 1, 2, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Instruction fetch sequencer and ROM port arbiter for the 8-bit RISC CPU. It owns the program counter, drives the ROM's addr/read/ena, and assembles one- or two-byte instructions for the decoder through a valid/ready handshake. It also shares the single ROM port with the execute stage's constant-load (LDO) data reads.

## Interface
Parameters:
- none. Widths are fixed at 8-bit address/data and a 4-bit opcode / 4-bit register field.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  8  ROM address; combinational from the grant.
- rom_read  out  1  ROM read strobe; high only in grant cycles.
- rom_ena  out  1  ROM enable; equal to rom_read.
- rom_data  in  8  ROM data; combinational ROM, valid in the same cycle as rom_addr.
- ins_valid  out  1  instruction available.
- ins_ready  in  1  decoder accepts the instruction.
- ins_opcode  out  4  bits [7:4] of the opcode byte.
- ins_reg  out  4  bits [3:0] of the opcode byte.
- ins_operand  out  8  second byte; 0 for one-byte instructions.
- ins_two_byte  out  1  instruction had an operand byte.
- ins_pc  out  8  address of the opcode byte.
- dreq_valid  in  1  data-read request from execute.
- dreq_addr  in  8  ROM address for the data read.
- dreq_ready  out  1  data request granted this cycle.
- drsp_valid  out  1  one-cycle pulse; read data present.
- drsp_data  out  8  data for the granted read.
- jump_valid  in  1  redirect the PC.
- jump_addr  in  8  redirect target.
- halted  out  1  HLT accepted; fetch stopped.

## Operation
- Opcodes with an operand byte: 0001 LDO, 0010 LDA, 0011 STO. All other opcodes are one byte. 0111 is HLT.
- States:
  - FETCH_OP: read byte at PC into the opcode register, PC+1. Next state is FETCH_ARG if the opcode is two-byte, else HOLD.
  - FETCH_ARG: read byte at PC into the operand register, PC+1. Next state is HOLD.
  - HOLD: ins_valid=1. On ins_ready, go to HALT if opcode=0111, else FETCH_OP.
  - HALT: halted=1. No fetch reads.
- PC is 8 bits and wraps 255 to 0. An operand byte at 255 is followed by a fetch at 0.
- Arbitration, one ROM access per cycle:
  - A fetch request exists in FETCH_OP and FETCH_ARG.
  - The data request wins by default and is serviced in every state, including HOLD and HALT.
  - Fairness: if the previous cycle granted data and a fetch request is pending, fetch wins and dreq_ready=0.
  - A losing fetch stays in its state with PC unchanged.
- Data grant: dreq_ready=1, rom_addr=dreq_addr, rom_data registered. drsp_valid=1 the next cycle, with drsp_data held until the next grant.
- Jump (jump_valid=1, any state):
  - PC takes jump_addr, state goes to FETCH_OP, halted clears, ins_valid=0 next cycle.
  - A partially fetched instruction is discarded.
  - An ins handshake in the same cycle still counts as consumed.
  - The jump does not block a data grant that cycle. A fetch grant that cycle is discarded.
- Instruction outputs are stable while ins_valid=1 and ins_ready=0.

## Timing
- Reset: PC=0, state FETCH_OP, ins_valid=0, ins_opcode/ins_reg/ins_operand/ins_pc=0, ins_two_byte=0, drsp_valid=0, drsp_data=0, halted=0. While rst=1, rom_read=rom_ena=0, dreq_ready=0, rom_addr=0.
- Reset mid-operation aborts any fetch. A data grant in that cycle is dropped, with no drsp_valid.
- First fetch cycle is the first cycle with rst=0.
- One-byte instruction: fetch in cycle N, ins_valid from N+1.
- Two-byte instruction: fetch in N and N+1, ins_valid from N+2.
- After a handshake in HOLD, the next FETCH_OP is the following cycle. Peak rate is one one-byte instruction per 2 cycles.
- Each data grant stalls fetch by exactly one cycle.
- Under continuous dreq_valid with fetch pending, grants alternate data/fetch.

## Test plan
- Reset released, ins_ready=1, ROM[0]=00, ROM[1..2]=11,61:
  - cycle 1: ins_valid with opcode 0, reg 0, pc 0, two_byte 0.
  - later: opcode 1, reg 1, operand 0x61, pc 1, two_byte 1, ins_valid 2 cycles after its FETCH_OP.
- dreq_valid=1, dreq_addr=0x61 (ROM=0x15) during FETCH_OP at PC=3 -> dreq_ready=1, rom_addr=0x61; next cycle drsp_valid=1, drsp_data=0x15; opcode at 3 fetched one cycle late.
- dreq_valid held high for 6 cycles from FETCH_OP -> dreq_ready pattern 1,0,1,0,1,0 (second pulse only if fetch still pending); the instruction still completes.
- ins_ready=0 for 5 cycles in HOLD -> all ins_* outputs constant, PC unchanged, no fetch reads; data reads still granted.
- ROM[40]=0x70 (HLT) accepted -> halted=1, rom_read=0 except data grants; jump_valid with jump_addr=0 -> halted=0, next cycle fetches address 0.
- Jump to 0xFF holding a one-byte opcode -> next fetch at 0x00. rst=1 during FETCH_ARG -> all outputs at reset values, fetch restarts at 0.
